// File: rtl/dsp_mac_pkg.sv
// Shared constants for the DSP MAC pipeline: OPMODE bit positions and the
// Z-operand select encoding used by the post-adder stage.
package dsp_mac_pkg;

    localparam int OP_PRE_EN   = 0;
    localparam int OP_PRE_SUB  = 1;
    localparam int OP_ZSEL_LO  = 2;
    localparam int OP_ZSEL_HI  = 3;
    localparam int OP_POST_SUB = 4;

    typedef enum logic [1:0] {
        ZSEL_ZERO = 2'b00,
        ZSEL_C    = 2'b01,
        ZSEL_P    = 2'b10,
        ZSEL_RSVD = 2'b11
    } zsel_e;

endpackage

// File: rtl/dsp_mac_postadd.sv
// Combinational post-adder: Z +/- M +/- carry-in with carry-out, signed
// overflow detection and optional saturation of the PW-bit result.
module dsp_mac_postadd #(
    parameter int PW     = 48,
    parameter bit SAT_EN = 1'b0
) (
    input  logic [PW-1:0] z,
    input  logic [PW-1:0] m,
    input  logic          cin,
    input  logic          sub,
    output logic [PW-1:0] p,
    output logic          carry_out,
    output logic          overflow
);

    logic [PW:0] sum_u_s;
    logic [PW:0] sum_s_s;

    // Unsigned sum supplies the carry (inverted borrow when subtracting); the
    // sign-extended sum exposes overflow as a mismatch of its top two bits.
    always_comb begin
        if (sub) begin
            sum_u_s = {1'b0, z} + {1'b0, ~m} + {{PW{1'b0}}, ~cin};
            sum_s_s = {z[PW-1], z} - {m[PW-1], m} - {{PW{1'b0}}, cin};
        end else begin
            sum_u_s = {1'b0, z} + {1'b0, m} + {{PW{1'b0}}, cin};
            sum_s_s = {z[PW-1], z} + {m[PW-1], m} + {{PW{1'b0}}, cin};
        end
        carry_out = sum_u_s[PW];
        overflow  = sum_s_s[PW] ^ sum_s_s[PW-1];
        if (SAT_EN && overflow) begin
            p = sum_s_s[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
        end else begin
            p = sum_s_s[PW-1:0];
        end
    end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Four-stage pre-add / multiply / post-add MAC pipeline with clock enable,
// valid qualifier and optional P accumulation feedback.
module dsp_mac_pipe
    import dsp_mac_pkg::*;
#(
    parameter int AW     = 18,
    parameter int BW     = 18,
    parameter int PW     = 48,
    parameter bit SAT_EN = 1'b0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CE,
    input  logic                IN_VALID,
    input  logic [AW-1:0]       A,
    input  logic [BW-1:0]       B,
    input  logic [BW-1:0]       D,
    input  logic [PW-1:0]       C,
    input  logic [4:0]          OPMODE,
    input  logic                CARRYIN,
    output logic                OUT_VALID,
    output logic [PW-1:0]       P,
    output logic [AW+BW:0]      M,
    output logic                CARRYOUT,
    output logic                OVERFLOW
);

    localparam int MW = AW + BW + 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [BW-1:0] d;
        logic [PW-1:0] c;
        logic [4:0]    op;
        logic          cin;
        logic          vld;
    } s1_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW:0]   pre;
        logic [PW-1:0] c;
        logic [1:0]    zsel;
        logic          sub;
        logic          cin;
        logic          vld;
    } s2_t;

    typedef struct packed {
        logic [MW-1:0] m;
        logic [PW-1:0] c;
        logic [1:0]    zsel;
        logic          sub;
        logic          cin;
        logic          vld;
    } s3_t;

    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;
    s3_t s3_q, s3_d;

    logic [PW-1:0] p_q, p_d;
    logic          co_q, co_d;
    logic          ovf_q, ovf_d;
    logic          vld_q, vld_d;

    logic signed [BW:0]   b_ext_s;
    logic signed [BW:0]   d_ext_s;
    logic signed [BW:0]   pre_s;
    logic signed [MW-1:0] prod_s;
    zsel_e                zsel_s;
    logic [PW-1:0]        z_s;
    logic [PW-1:0]        m_ext_s;
    logic [PW-1:0]        p_res_s;
    logic                 co_res_s;
    logic                 ovf_res_s;

    // Stage 1: capture raw operands and control
    always_comb begin
        s1_d = s1_q;
        if (CE) begin
            s1_d = '{a: A, b: B, d: D, c: C, op: OPMODE, cin: CARRYIN, vld: IN_VALID};
        end else begin
            s1_d = s1_q;
        end
    end

    // Stage 2: pre-adder at BW+1 bits so D+B and D-B never wrap
    always_comb begin
        b_ext_s = $signed({s1_q.b[BW-1], s1_q.b});
        d_ext_s = $signed({s1_q.d[BW-1], s1_q.d});
        if (s1_q.op[OP_PRE_EN]) begin
            pre_s = s1_q.op[OP_PRE_SUB] ? (d_ext_s - b_ext_s) : (d_ext_s + b_ext_s);
        end else begin
            pre_s = b_ext_s;
        end
        s2_d = s2_q;
        if (CE) begin
            s2_d = '{a: s1_q.a, pre: pre_s, c: s1_q.c,
                     zsel: s1_q.op[OP_ZSEL_HI:OP_ZSEL_LO], sub: s1_q.op[OP_POST_SUB],
                     cin: s1_q.cin, vld: s1_q.vld};
        end else begin
            s2_d = s2_q;
        end
    end

    // Stage 3: signed multiply; M register also feeds the M output port
    always_comb begin
        prod_s = MW'($signed(s2_q.a)) * MW'($signed(s2_q.pre));
        s3_d   = s3_q;
        if (CE) begin
            s3_d = '{m: prod_s, c: s2_q.c, zsel: s2_q.zsel, sub: s2_q.sub,
                     cin: s2_q.cin, vld: s2_q.vld};
        end else begin
            s3_d = s3_q;
        end
    end

    // Stage 4 operand select; Z=P reads the live P register for back-to-back accumulation
    always_comb begin
        zsel_s  = zsel_e'(s3_q.zsel);
        m_ext_s = {{(PW-MW){s3_q.m[MW-1]}}, s3_q.m};
        case (zsel_s)
            ZSEL_ZERO: z_s = {PW{1'b0}};
            ZSEL_C:    z_s = s3_q.c;
            ZSEL_P:    z_s = p_q;
            ZSEL_RSVD: z_s = {PW{1'b0}};
            default:   z_s = {PW{1'b0}};
        endcase
    end

    dsp_mac_postadd #(
        .PW     (PW),
        .SAT_EN (SAT_EN)
    ) u_postadd (
        .z         (z_s),
        .m         (m_ext_s),
        .cin       (s3_q.cin),
        .sub       (s3_q.sub),
        .p         (p_res_s),
        .carry_out (co_res_s),
        .overflow  (ovf_res_s)
    );

    // Stage 4 result registers change only for valid samples; bubbles leave P intact
    always_comb begin
        p_d   = p_q;
        co_d  = co_q;
        ovf_d = ovf_q;
        vld_d = vld_q;
        if (CE) begin
            vld_d = s3_q.vld;
            if (s3_q.vld) begin
                p_d   = p_res_s;
                co_d  = co_res_s;
                ovf_d = ovf_res_s;
            end else begin
                p_d   = p_q;
                co_d  = co_q;
                ovf_d = ovf_q;
            end
        end else begin
            vld_d = vld_q;
        end
    end

    // Pipeline state registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            p_q   <= {PW{1'b0}};
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            p_q   <= p_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
            vld_q <= vld_d;
        end
    end

    assign OUT_VALID = vld_q;
    assign P         = p_q;
    assign M         = s3_q.m;
    assign CARRYOUT  = co_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench for dsp_mac_pipe: a wrapping and a saturating instance share
// stimulus; a monitor checks every output sample against queued expectations.
module tb_dsp_mac_pipe;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CE = 1'b1;
    logic        IN_VALID = 1'b0;
    logic [17:0] A = 18'd0;
    logic [17:0] B = 18'd0;
    logic [17:0] D = 18'd0;
    logic [47:0] C = 48'd0;
    logic [4:0]  OPMODE = 5'd0;
    logic        CARRYIN = 1'b0;

    logic        ov_w, co_w, ovf_w, ov_s, co_s, ovf_s;
    logic [47:0] p_w, p_s;
    logic [36:0] m_w, m_s;

    typedef struct {
        logic [47:0] pw;
        logic [47:0] ps;
        logic [36:0] m;
        logic        co;
        logic        ovf;
        int          lat;
        int          issue;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    logic        ce_seen = 1'b0;
    logic [36:0] m_prev = 37'd0;

    dsp_mac_pipe #(.AW(18), .BW(18), .PW(48), .SAT_EN(1'b0)) dut_w (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .IN_VALID(IN_VALID),
        .A(A), .B(B), .D(D), .C(C), .OPMODE(OPMODE), .CARRYIN(CARRYIN),
        .OUT_VALID(ov_w), .P(p_w), .M(m_w), .CARRYOUT(co_w), .OVERFLOW(ovf_w)
    );

    dsp_mac_pipe #(.AW(18), .BW(18), .PW(48), .SAT_EN(1'b1)) dut_s (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .IN_VALID(IN_VALID),
        .A(A), .B(B), .D(D), .C(C), .OPMODE(OPMODE), .CARRYIN(CARRYIN),
        .OUT_VALID(ov_s), .P(p_s), .M(m_s), .CARRYOUT(co_s), .OVERFLOW(ovf_s)
    );

    always #5 CLK = ~CLK;

    // Edge counter for latency measurement and record of whether the edge was enabled
    always @(posedge CLK) begin
        edge_cnt <= edge_cnt + 1;
        ce_seen  <= CE;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each enabled edge that leaves OUT_VALID high presents one new result
    always @(negedge CLK) begin
        if (RST_N && ce_seen && ov_w) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: OUT_VALID=1 P=%0h with nothing expected", p_w);
            end else begin
                e = sb.pop_front();
                chk("p_wrap", 64'(p_w), 64'(e.pw));
                chk("p_sat", 64'(p_s), 64'(e.ps));
                chk("m", 64'(m_prev), 64'(e.m));
                chk("carryout", 64'(co_w), 64'(e.co));
                chk("overflow_wrap", 64'(ovf_w), 64'(e.ovf));
                chk("overflow_sat", 64'(ovf_s), 64'(e.ovf));
                chk("out_valid_sat", 64'(ov_s), 64'd1);
                chk("latency", 64'(edge_cnt - e.issue), 64'(e.lat));
            end
        end
        m_prev = m_w;
    end

    task automatic issue(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                         input logic [47:0] c, input logic [4:0] op, input logic cin,
                         input logic [47:0] pw, input logic [47:0] ps, input logic [36:0] m,
                         input logic co, input logic ovf, input int lat, input bit push);
        exp_t x;
        @(negedge CLK);
        A = a; B = b; D = d; C = c; OPMODE = op; CARRYIN = cin; IN_VALID = 1'b1;
        if (push) begin
            x.pw = pw; x.ps = ps; x.m = m; x.co = co; x.ovf = ovf;
            x.lat = lat; x.issue = edge_cnt;
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            IN_VALID = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_p"}, 64'(p_w), 64'd0);
        chk({tag, "_m"}, 64'(m_w), 64'd0);
        chk({tag, "_out_valid"}, 64'(ov_w), 64'd0);
        chk({tag, "_carryout"}, 64'(co_w), 64'd0);
        chk({tag, "_overflow"}, 64'(ovf_w), 64'd0);
        chk({tag, "_p_sat"}, 64'(p_s), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk_zero("reset");
        RST_N = 1'b1;

        // Accumulate straight after reset: Z=P, no pre-add, M=3 each sample
        issue(18'd3, 18'd1, 18'd0, 48'd0, 5'b01000, 1'b0, 48'd3,  48'd3,  37'd3, 1'b0, 1'b0, 4, 1'b1);
        issue(18'd3, 18'd1, 18'd0, 48'd0, 5'b01000, 1'b0, 48'd6,  48'd6,  37'd3, 1'b0, 1'b0, 4, 1'b1);
        issue(18'd3, 18'd1, 18'd0, 48'd0, 5'b01000, 1'b0, 48'd9,  48'd9,  37'd3, 1'b0, 1'b0, 4, 1'b1);
        issue(18'd3, 18'd1, 18'd0, 48'd0, 5'b01000, 1'b0, 48'd12, 48'd12, 37'd3, 1'b0, 1'b0, 4, 1'b1);
        issue(18'd3, 18'd1, 18'd0, 48'd0, 5'b01000, 1'b0, 48'd15, 48'd15, 37'd3, 1'b0, 1'b0, 4, 1'b1);
        idle(6);

        // D+B pre-add, Z=0
        issue(18'd2, 18'd3, 18'd6, 48'd0, 5'b00001, 1'b0, 48'd18, 48'd18, 37'd18, 1'b0, 1'b0, 4, 1'b1);
        // D-B pre-add, Z=C, carry-in
        issue(18'd2, 18'd4, 18'd2, 48'd10, 5'b00111, 1'b1, 48'd7, 48'd7,
              37'h1F_FFFF_FFFC, 1'b1, 1'b0, 4, 1'b1);
        // Positive overflow: wrap vs clamp
        issue(18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 5'b00100, 1'b0,
              48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF, 37'd1, 1'b0, 1'b1, 4, 1'b1);
        // Negative overflow via post-subtract
        issue(18'd1, 18'd1, 18'd0, 48'h8000_0000_0000, 5'b10100, 1'b0,
              48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000, 37'd1, 1'b1, 1'b1, 4, 1'b1);
        // Negative product, overflow flag must drop again
        issue(18'h3FFFB, 18'd7, 18'd0, 48'd0, 5'b00000, 1'b0,
              48'hFFFF_FFFF_FFDD, 48'hFFFF_FFFF_FFDD, 37'h1F_FFFF_FFDD, 1'b0, 1'b0, 4, 1'b1);
        // Pre-subtract and post-subtract with carry-in: 100 - (-18) - 1
        issue(18'd3, 18'd10, 18'd4, 48'd100, 5'b10111, 1'b1, 48'd117, 48'd117,
              37'h1F_FFFF_FFEE, 1'b0, 1'b0, 4, 1'b1);
        // Reserved Z select behaves as zero
        issue(18'd4, 18'd5, 18'd0, 48'd999, 5'b01100, 1'b0, 48'd20, 48'd20, 37'd20, 1'b0, 1'b0, 4, 1'b1);
        // Most negative operands: (-2^17) * (-2^18) = 2^35
        issue(18'h20000, 18'h20000, 18'h20000, 48'd0, 5'b00001, 1'b0,
              48'h0008_0000_0000, 48'h0008_0000_0000, 37'h08_0000_0000, 1'b0, 1'b0, 4, 1'b1);
        idle(6);

        // CE low for three cycles right after acceptance delays the result by three
        issue(18'd5, 18'd6, 18'd0, 48'd0, 5'b00000, 1'b0, 48'd30, 48'd30, 37'd30, 1'b0, 1'b0, 7, 1'b1);
        @(negedge CLK);
        IN_VALID = 1'b0;
        CE = 1'b0;
        repeat (3) @(negedge CLK);
        CE = 1'b1;
        idle(3);
        // Bubbles and the freeze must leave P=30 for this accumulate
        issue(18'd1, 18'd2, 18'd0, 48'd0, 5'b01000, 1'b0, 48'd32, 48'd32, 37'd2, 1'b0, 1'b0, 4, 1'b1);
        idle(8);

        // Two samples in flight, then an asynchronous reset between edges
        issue(18'd7, 18'd7, 18'd0, 48'd0, 5'b00000, 1'b0, 48'd0, 48'd0, 37'd0, 1'b0, 1'b0, 4, 1'b0);
        issue(18'd7, 18'd7, 18'd0, 48'd0, 5'b00000, 1'b0, 48'd0, 48'd0, 37'd0, 1'b0, 1'b0, 4, 1'b0);
        @(negedge CLK);
        IN_VALID = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge CLK);
        RST_N = 1'b1;
        idle(10);

        // First accumulate after reset starts from P=0
        issue(18'd2, 18'd2, 18'd0, 48'd0, 5'b01000, 1'b0, 48'd4, 48'd4, 37'd4, 1'b0, 1'b0, 4, 1'b1);
        idle(8);

        for (int i = 0; i < 30 && sb.size() != 0; i++) begin
            @(negedge CLK);
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_out: expected P=%0h never appeared", e.pw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
